// File: rtl/data_memory_responder.sv
// Word-addressed data memory slave with a fixed number of wait states.
// Handshake: stall_o freezes the requester until a one-cycle ready_o completion pulse.
module data_memory_responder #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 64,
  parameter int          WAIT_STATES  = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [31:0]           address_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  ready_o,
  output logic                  stall_o,
  output logic                  addr_error_o
);

  localparam int         IDX_W     = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state, state_nxt;
  logic [3:0]            wait_cnt, wait_cnt_nxt;
  logic                  op_write, op_conflict, err_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  logic                  request, accept, enter_done;
  logic [31:0]           cur_addr, cur_offset, cur_word;
  logic                  cur_write, cur_conflict, cur_ok;
  logic [IDX_W-1:0]      cur_index, wr_index;

  assign request = mem_read_i | mem_write_i;
  assign accept  = (state == IDLE) && request;

  // With zero wait states completion follows acceptance directly, so the
  // checks must see the live request in IDLE and the latched one afterwards.
  assign cur_addr     = (state == IDLE) ? address_i : addr_q;
  assign cur_write    = (state == IDLE) ? mem_write_i : op_write;
  assign cur_conflict = (state == IDLE) ? (mem_read_i & mem_write_i) : op_conflict;
  assign cur_offset   = cur_addr - BASE_ADDR;
  assign cur_word     = cur_offset >> 2;
  assign cur_index    = cur_word[IDX_W-1:0];
  assign cur_ok       = (cur_addr[1:0] == 2'b00) && (cur_word < 32'(MEMORY_DEPTH))
                        && !cur_conflict;
  assign wr_index     = cur_index;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      IDLE: begin
        if (request) begin
          wait_cnt_nxt = WAIT_LOAD;
          state_nxt    = (WAIT_STATES > 0) ? ACCESS : DONE;
        end
      end
      ACCESS: begin
        wait_cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt <= 4'd1) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_done = (state_nxt == DONE) && (state != DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      op_write    <= 1'b0;
      op_conflict <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_data_o <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept) begin
        op_write    <= mem_write_i;
        op_conflict <= mem_read_i & mem_write_i;
        addr_q      <= address_i;
        wdata_q     <= write_data_i;
      end
      if (enter_done) begin
        err_q <= !cur_ok;
        if (!cur_ok)        read_data_o <= '0;
        else if (!cur_write) read_data_o <= mem[cur_index];
      end
    end
  end

  // NOTE: the storage array has no reset; contents survive reset, and an
  // asynchronous reset forces state to IDLE so an aborted DONE never writes.
  always_ff @(posedge clk) begin
    if (state == DONE && op_write && !err_q) mem[wr_index] <= wdata_q;
  end

  assign ready_o      = (state == DONE);
  assign addr_error_o = (state == DONE) && err_q;
  assign stall_o      = reset && (accept || (state == ACCESS));

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: a WAIT_STATES=2 instance for the main scenarios and a
// WAIT_STATES=0 instance for the continuous-request pulse pattern.
module tb_data_memory_responder;

  localparam int          WAIT = 2;
  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        ready, stall, err;

  logic        rd0 = 1'b0, wr0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [31:0] rdata0;
  logic        ready0, stall0, err0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [64];
  logic [31:0] model_rdata = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.DATA_WIDTH(32), .MEMORY_DEPTH(64), .WAIT_STATES(WAIT),
                          .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .mem_read_i(rd), .mem_write_i(wr),
    .address_i(addr), .write_data_i(wdata), .read_data_o(rdata),
    .ready_o(ready), .stall_o(stall), .addr_error_o(err));

  data_memory_responder #(.DATA_WIDTH(32), .MEMORY_DEPTH(64), .WAIT_STATES(0),
                          .BASE_ADDR(BASE)) dut0 (
    .clk(clk), .reset(reset), .mem_read_i(rd0), .mem_write_i(wr0),
    .address_i(addr0), .write_data_i(wdata0), .read_data_o(rdata0),
    .ready_o(ready0), .stall_o(stall0), .addr_error_o(err0));

  // One access on the WAIT_STATES=2 instance; inputs are scrambled after
  // acceptance, and completion is bounded by a cycle budget.
  task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input string name);
    exp_t        e, got;
    logic [31:0] off, idx;
    bit          ok, seen;
    off = a - BASE;
    idx = off >> 2;
    ok  = (a[1:0] == 2'b00) && (idx < 32'd64) && !(r && w);
    if (!ok)    model_rdata = '0;
    else if (w) model_mem[idx[5:0]] = d;
    else        model_rdata = model_mem[idx[5:0]];
    e.rdata = model_rdata;
    e.err   = !ok;
    sb.push_back(e);

    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_err++; $display("FAIL %s stall_accept: got %b want 1", name, stall);
    end
    seen = 0;
    for (int k = 1; k <= WAIT + 4 && !seen; k++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        seen = 1;
        got  = sb.pop_front();
        n_cmp++;
        if (k != WAIT + 1) begin
          n_err++; $display("FAIL %s latency: got %0d want %0d", name, k, WAIT + 1);
        end
        n_cmp++;
        if (rdata !== got.rdata) begin
          n_err++; $display("FAIL %s read_data: got %h want %h", name, rdata, got.rdata);
        end
        n_cmp++;
        if (err !== got.err) begin
          n_err++; $display("FAIL %s addr_error: got %b want %b", name, err, got.err);
        end
        n_cmp++;
        if (stall !== 1'b0) begin
          n_err++; $display("FAIL %s stall_done: got %b want 0", name, stall);
        end
        rd = 1'b0; wr = 1'b0;
      end else begin
        n_cmp++;
        if (stall !== 1'b1 || err !== 1'b0) begin
          n_err++; $display("FAIL %s access_cycle%0d: stall=%b err=%b want 1/0", name, k, stall, err);
        end
        rd = !r; wr = !w; addr = $urandom; wdata = $urandom;
      end
    end
    if (!seen) begin
      void'(sb.pop_front());
      n_cmp++; n_err++;
      $display("FAIL %s timeout: no ready_o within %0d cycles", name, WAIT + 4);
      rd = 1'b0; wr = 1'b0;
    end
  endtask

  task automatic test_reset();
    rd = 1'b1; wr = 1'b1; rd0 = 1'b1; addr = BASE; reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if ({rdata, ready, stall, err} !== 35'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h/%b/%b/%b want 0", rdata, ready, stall, err);
    end
    n_cmp++;
    if ({rdata0, ready0, stall0, err0} !== 35'd0) begin
      n_err++; $display("FAIL reset_outputs0: got %h/%b/%b/%b want 0", rdata0, ready0, stall0, err0);
    end
    rd = 1'b0; wr = 1'b0; rd0 = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic test_write_read();
    do_access(1'b0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, "first_write");
    do_access(1'b1, 1'b0, 32'h1001_0004, 32'h0, "raw_read");
  endtask

  task automatic test_fill();
    do_access(1'b0, 1'b1, BASE,                32'h0000_1111, "fill_w0");
    do_access(1'b0, 1'b1, BASE + 32'd8,        32'h2222_2222, "fill_w2");
    do_access(1'b0, 1'b1, BASE + 32'd12,       32'h3333_3333, "fill_w3");
    do_access(1'b0, 1'b1, BASE + 32'd252,      32'h6363_6363, "fill_w63");
    do_access(1'b1, 1'b0, BASE + 32'd252,      32'h0,         "read_w63");
  endtask

  task automatic test_misaligned();
    do_access(1'b1, 1'b0, 32'h1001_0002, 32'h0, "misaligned_read");
    do_access(1'b0, 1'b1, 32'h1001_0006, 32'hBAD0_BAD0, "misaligned_write");
    do_access(1'b1, 1'b0, 32'h1001_0004, 32'h0, "w1_unchanged");
  endtask

  task automatic test_out_of_range();
    do_access(1'b0, 1'b1, 32'h1001_0100, 32'hFFFF_0000, "oor_write");
    do_access(1'b1, 1'b0, BASE,          32'h0, "w0_after_oor");
    do_access(1'b1, 1'b0, BASE + 32'd252, 32'h0, "w63_after_oor");
    do_access(1'b1, 1'b0, 32'h1000_FFFC, 32'h0, "below_base_read");
  endtask

  task automatic test_conflict();
    do_access(1'b1, 1'b0, BASE + 32'd8, 32'h0, "prime_rdata");
    do_access(1'b1, 1'b1, BASE + 32'd8, 32'hC0FF_EE00, "conflict");
    do_access(1'b1, 1'b0, BASE + 32'd8, 32'h0, "w2_after_conflict");
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    wr = 1'b1; addr = BASE + 32'd12; wdata = 32'h1234_5678;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({rdata, ready, stall, err} !== 35'd0) begin
      n_err++; $display("FAIL abort_reset_outputs: got %h/%b/%b/%b want 0", rdata, ready, stall, err);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({rdata, ready, stall, err} !== 35'd0) begin
      n_err++; $display("FAIL abort_reset_edge: got %h/%b/%b/%b want 0", rdata, ready, stall, err);
    end
    wr = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_rdata = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ready !== 1'b0) begin
        n_err++; $display("FAIL abort_no_ready: cycle %0d got %b want 0", i, ready);
      end
    end
    do_access(1'b1, 1'b0, BASE + 32'd12, 32'h0, "w3_after_abort");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    wr0 = 1'b1; addr0 = BASE + 32'd20; wdata0 = 32'h5A5A_0005;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_cmp++;
      if (ready0 !== i[0] || stall0 !== !i[0] || err0 !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_pulse%0d: ready=%b stall=%b err=%b want %b/%b/0", i, ready0, stall0, err0, i[0], !i[0]);
      end
      if (i[0] && ready0 === 1'b1 && rd0 === 1'b1) begin
        n_cmp++;
        if (rdata0 !== 32'h5A5A_0005) begin
          n_err++; $display("FAIL b2b_read%0d: got %h want 5a5a0005", i, rdata0);
        end
      end
      if (i == 5) begin
        wr0 = 1'b0; rd0 = 1'b1;
      end
    end
    rd0 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_fill();
    test_misaligned();
    test_out_of_range();
    test_conflict();
    test_reset_abort();
    test_back_to_back();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 32, data word width in bits
- MEMORY_DEPTH, 64, number of words stored
- WAIT_STATES, 2, extra cycles inserted before completion; legal range 0..15
- BASE_ADDR, 32'h1001_0000, byte address of word 0
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, input, 1, single clock; all state changes on the rising edge
- reset, input, 1, asynchronous, active-low reset
- mem_read_i, input, 1, read request (level)
- mem_write_i, input, 1, write request (level)
- address_i, input, 32, byte address
- write_data_i, input, DATA_WIDTH, store data
- read_data_o, output, DATA_WIDTH, load data
- ready_o, output, 1, one-cycle completion pulse
- stall_o, output, 1, hold request: pipeline must freeze
- addr_error_o, output, 1, completion was rejected (bad address or conflicting request)
REQ-003 The block SHALL have one clock, clk. Reset SHALL be reset, asynchronous and active-low.

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-005 In IDLE, a request (mem_read_i or mem_write_i high) SHALL be accepted at the clock edge. On acceptance the block SHALL latch the operation, address_i and write_data_i, and load the wait counter with WAIT_STATES.
REQ-006 State transitions on acceptance:
- IDLE -> ACCESS when WAIT_STATES > 0
- IDLE -> DONE when WAIT_STATES = 0
REQ-007 In ACCESS the wait counter SHALL decrement every cycle. The FSM SHALL move ACCESS -> DONE on the edge where the counter is 1.
REQ-008 DONE SHALL last exactly one cycle, then return to IDLE. Requests are level-sensitive and are accepted only in IDLE. A request still high in the IDLE cycle after DONE is a new access.
REQ-009 Latency: ready_o SHALL be high exactly in cycle N+WAIT_STATES+1, where N is the acceptance cycle (the IDLE cycle with a request).
REQ-010 stall_o SHALL be asserted (combinationally) in these cases, and low otherwise:
- IDLE with a request present
- any ACCESS cycle
REQ-011 Address check: word index = (latched address - BASE_ADDR) >> 2. An access is valid only if both hold:
- latched address[1:0] = 0
- 0 <= index < MEMORY_DEPTH
REQ-012 Valid write: memory[index] SHALL be updated at the DONE-cycle edge, not earlier.
REQ-013 Valid read: read_data_o SHALL be updated at the ACCESS->DONE (or IDLE->DONE) edge with memory[index], so the data is stable while ready_o is high. It SHALL hold until the next completed valid read.
REQ-014 Invalid access, or mem_read_i and mem_write_i both high at acceptance:
- the access still completes with normal latency
- addr_error_o SHALL be high in the DONE cycle only, coincident with ready_o
- no memory write occurs
- read_data_o SHALL be set to 0
REQ-015 Changes on address_i, write_data_i or the request lines after acceptance SHALL have no effect until the next acceptance.
REQ-016 Read-after-write to the same address in consecutive accesses SHALL return the newly written data.

Reset
REQ-017 While reset = 0, regardless of clk:
- FSM = IDLE
- wait counter = 0
- read_data_o = 0, ready_o = 0, stall_o = 0, addr_error_o = 0
REQ-018 Reset asserted mid-access (ACCESS or DONE before its edge) SHALL abort the access. No memory write occurs and no ready_o pulse is produced after release.
REQ-019 Memory contents SHALL NOT be cleared by reset.
REQ-020 The first acceptance is possible on the first rising edge after reset deasserts.

Verification
REQ-021 With WAIT_STATES=2: write 32'hDEAD_BEEF to 32'h1001_0004 in cycle 0, then read the same address.
- Write: stall_o high in cycles 0-2, ready_o high in cycle 3.
- Read: read_data_o = 32'hDEAD_BEEF with ready_o, addr_error_o = 0.
REQ-022 Read 32'h1001_0002 (misaligned) -> addr_error_o = 1 and ready_o = 1 in the DONE cycle, read_data_o = 0, memory unchanged.
REQ-023 Write to 32'h1001_0100 (index 64, out of range) -> addr_error_o pulse, no word 0..63 modified.
REQ-024 Assert mem_read_i and mem_write_i together -> addr_error_o pulse, no write, read_data_o = 0.
REQ-025 Pull reset low during ACCESS of a write of 32'h1234_5678 to word 3, then release:
- no ready_o pulse after release
- a subsequent read of word 3 returns its prior value
- all outputs are 0 during reset
REQ-026 With WAIT_STATES=0, a request held high continuously -> ready_o pulses every 2 cycles (IDLE, DONE alternating), stall_o high only in IDLE cycles.
